// File: rtl/matrix_pkg.sv
// Shared types and default dimensions for the per-layer weight matrix store
// and its readers.
package matrix_pkg;

    localparam int MATRIX_SIZE = 3;
    localparam int DATA_SIZE   = 16;
    localparam int MAX_LAYER   = 36;

    typedef logic [DATA_SIZE*MATRIX_SIZE-1:0] row_t;
    typedef logic signed [DATA_SIZE-1:0]      elem_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FINISH = 2'd2
    } reader_state_e;

endpackage

// File: rtl/matrix_row_reader.sv
// Streams the rows of one stored layer matrix onto a valid/ready interface.
// Optional start-layer range check: MATRIX_READER_LAYER_CHECK_EN.
module matrix_row_reader
    import matrix_pkg::*;
#(
    parameter int SIZE       = MATRIX_SIZE,
    parameter int ELEM_W     = DATA_SIZE,
    parameter int MAX_LAYERS = MAX_LAYER
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [31:0]              start_layer,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [31:0]              read_layer_index,
    output logic [31:0]              read_row_index,
    output logic                     is_read,
    input  logic [ELEM_W*SIZE-1:0]   read_data,
    output logic [ELEM_W*SIZE-1:0]   row_data,
    output logic [31:0]              row_index,
    output logic                     row_last,
    output logic                     row_valid,
    input  logic                     row_ready
);

    localparam int ROW_W = ELEM_W * SIZE;

`ifdef MATRIX_READER_LAYER_CHECK_EN
    localparam bit LAYER_CHECK = 1'b1;
`else
    localparam bit LAYER_CHECK = 1'b0;
`endif

    reader_state_e     state_q, state_d;
    logic [31:0]       row_ptr_q, row_ptr_d;
    logic [31:0]       layer_q, layer_d;
    logic [ROW_W-1:0]  row_data_q, row_data_d;
    logic [31:0]       row_index_q, row_index_d;
    logic              row_last_q, row_last_d;
    logic              row_valid_q, row_valid_d;
    logic              err_q, err_d;

    logic              idle_start_s;
    logic              reject_s;
    logic              accept_s;
    logic              hs_s;
    logic              is_read_s;

    assign idle_start_s = (state_q == ST_IDLE) && start;
    assign reject_s     = LAYER_CHECK && idle_start_s && (start_layer >= 32'(MAX_LAYERS));
    assign accept_s     = idle_start_s && !reject_s;
    assign hs_s         = row_valid_q && row_ready;
    // A new read may only overwrite the output register once it is empty or being drained.
    assign is_read_s    = (state_q == ST_STREAM) && (row_ptr_q < 32'(SIZE)) &&
                          (!row_valid_q || row_ready);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) state_d = ST_STREAM;
                else          state_d = ST_IDLE;
            end
            ST_STREAM: begin
                if (hs_s && row_last_q) state_d = ST_FINISH;
                else                    state_d = ST_STREAM;
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM-decoded outputs and store read port
    always_comb begin
        busy             = (state_q != ST_IDLE);
        done             = (state_q == ST_FINISH);
        is_read          = is_read_s;
        if (state_q == ST_STREAM) begin
            read_layer_index = layer_q;
            read_row_index   = row_ptr_q;
        end else begin
            read_layer_index = 32'd0;
            read_row_index   = 32'd0;
        end
    end

    // Datapath next values: layer latch, row pointer and output row register
    always_comb begin
        layer_d     = layer_q;
        row_ptr_d   = row_ptr_q;
        row_data_d  = row_data_q;
        row_index_d = row_index_q;
        row_last_d  = row_last_q;
        row_valid_d = row_valid_q;
        err_d       = reject_s;
        if (accept_s) begin
            layer_d   = start_layer;
            row_ptr_d = 32'd0;
        end else begin
            layer_d   = layer_q;
        end
        if (is_read_s) begin
            row_data_d  = read_data;
            row_valid_d = 1'b1;
            row_index_d = row_ptr_q;
            row_last_d  = (row_ptr_q == 32'(SIZE - 1));
            row_ptr_d   = row_ptr_q + 32'd1;
        end else if (hs_s) begin
            row_valid_d = 1'b0;
        end else begin
            row_valid_d = row_valid_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            layer_q     <= 32'd0;
            row_ptr_q   <= 32'd0;
            row_data_q  <= '0;
            row_index_q <= 32'd0;
            row_last_q  <= 1'b0;
            row_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            layer_q     <= layer_d;
            row_ptr_q   <= row_ptr_d;
            row_data_q  <= row_data_d;
            row_index_q <= row_index_d;
            row_last_q  <= row_last_d;
            row_valid_q <= row_valid_d;
            err_q       <= err_d;
        end
    end

    assign row_data  = row_data_q;
    assign row_index = row_index_q;
    assign row_last  = row_last_q;
    assign row_valid = row_valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_matrix_row_reader.sv
// Directed bench for matrix_row_reader with a behavioural write-through store.
// Expects err behaviour according to MATRIX_READER_LAYER_CHECK_EN.
module tb_matrix_row_reader;
    import matrix_pkg::*;

    localparam int SZ = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] start_layer;
    logic        busy, done, err, is_read;
    logic [31:0] read_layer_index, read_row_index;
    logic [47:0] read_data;
    logic [47:0] row_data;
    logic [31:0] row_index;
    logic        row_last, row_valid;
    logic        row_ready;

    logic [47:0] mem [0:63][0:SZ-1];
    logic        wr_en;
    logic [31:0] wr_layer, wr_row;
    logic [47:0] wr_data;

    int          checks_cnt = 0;
    int          errors_cnt = 0;
    int          hs_cnt = 0;
    logic [31:0] hs_idx [0:255];

    matrix_row_reader dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .start_layer      (start_layer),
        .busy             (busy),
        .done             (done),
        .err              (err),
        .read_layer_index (read_layer_index),
        .read_row_index   (read_row_index),
        .is_read          (is_read),
        .read_data        (read_data),
        .row_data         (row_data),
        .row_index        (row_index),
        .row_last         (row_last),
        .row_valid        (row_valid),
        .row_ready        (row_ready)
    );

    always #5 clk = ~clk;

    // Store read port with same-cycle write-through
    always_comb begin
        read_data = 48'd0;
        if (read_row_index < 32'(SZ) && read_layer_index < 32'd64) begin
            if (wr_en && wr_layer == read_layer_index && wr_row == read_row_index)
                read_data = wr_data;
            else
                read_data = mem[read_layer_index[5:0]][read_row_index[1:0]];
        end
    end

    // Handshake log
    always @(posedge clk) begin
        if (!reset && row_valid && row_ready) begin
            hs_idx[hs_cnt[7:0]] <= row_index;
            hs_cnt <= hs_cnt + 1;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_full(input int layer);
        start = 1'b1;
        start_layer = 32'(layer);
        tick();
        start = 1'b0;
        #1;
        check_val("run_busy", 64'(busy), 64'd1);
        check_val("run_is_read", 64'(is_read), 64'd1);
        check_val("run_rd_layer", 64'(read_layer_index), 64'(layer));
        check_val("run_rd_row0", 64'(read_row_index), 64'd0);
        for (int r = 0; r < SZ; r++) begin
            tick();
            check_val($sformatf("run_L%0d_r%0d_valid", layer, r), 64'(row_valid), 64'd1);
            check_val($sformatf("run_L%0d_r%0d_index", layer, r), 64'(row_index), 64'(r));
            check_val($sformatf("run_L%0d_r%0d_data", layer, r), 64'(row_data), 64'(mem[layer][r]));
            check_val($sformatf("run_L%0d_r%0d_last", layer, r), 64'(row_last), (r == SZ - 1) ? 64'd1 : 64'd0);
        end
        tick();
        check_val("run_done", 64'(done), 64'd1);
        check_val("run_done_busy", 64'(busy), 64'd1);
        check_val("run_done_valid", 64'(row_valid), 64'd0);
        tick();
        check_val("run_after_done", 64'(done), 64'd0);
        check_val("run_after_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int seen_done;
        int seen_err;

        for (int l = 0; l < 64; l++)
            for (int r = 0; r < SZ; r++)
                mem[l][r] = {8'(l), 8'(r), 16'h1234, 16'h5678};
        mem[5][0] = {16'h0100, 16'h0200, 16'h0300};
        mem[5][1] = {16'h0400, 16'h0500, 16'h0600};
        mem[5][2] = {16'h0700, 16'h0800, 16'h0900};
        mem[7][0] = {16'hF800, 16'h0080, 16'h7FFF};
        mem[7][1] = {16'h8000, 16'hFFFF, 16'h0001};
        mem[7][2] = {16'h0C00, 16'hF400, 16'h0000};

        reset = 1'b1;
        start = 1'b0;
        start_layer = 32'd0;
        row_ready = 1'b1;
        wr_en = 1'b0;
        wr_layer = 32'd0;
        wr_row = 32'd0;
        wr_data = 48'd0;
        tick();
        tick();
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_err", 64'(err), 64'd0);
        check_val("rst_valid", 64'(row_valid), 64'd0);
        check_val("rst_is_read", 64'(is_read), 64'd0);
        check_val("rst_data", 64'(row_data), 64'd0);
        check_val("rst_index", 64'(row_index), 64'd0);
        check_val("rst_last", 64'(row_last), 64'd0);
        reset = 1'b0;
        tick();

        // Full-rate stream of layer 5
        base = hs_cnt;
        run_full(5);
        check_val("t1_hs_count", 64'(hs_cnt - base), 64'd3);

        // Backpressure while row 1 is presented
        base = hs_cnt;
        start = 1'b1;
        start_layer = 32'd5;
        tick();
        start = 1'b0;
        tick();
        check_val("t2_row0_index", 64'(row_index), 64'd0);
        tick();
        row_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check_val("t2_stall_valid", 64'(row_valid), 64'd1);
            check_val("t2_stall_index", 64'(row_index), 64'd1);
            check_val("t2_stall_data", 64'(row_data), 64'(mem[5][1]));
            check_val("t2_stall_is_read", 64'(is_read), 64'd0);
            tick();
        end
        check_val("t2_held_data", 64'(row_data), 64'(mem[5][1]));
        row_ready = 1'b1;
        #1;
        check_val("t2_resume_is_read", 64'(is_read), 64'd1);
        check_val("t2_resume_row", 64'(read_row_index), 64'd2);
        tick();
        check_val("t2_row2_data", 64'(row_data), 64'(mem[5][2]));
        check_val("t2_row2_last", 64'(row_last), 64'd1);
        tick();
        check_val("t2_done", 64'(done), 64'd1);
        tick();
        check_val("t2_hs_count", 64'(hs_cnt - base), 64'd3);
        for (int k = 0; k < 3; k++)
            check_val($sformatf("t2_order%0d", k), 64'(hs_idx[8'(base + k)]), 64'(k));

        // Start while busy is ignored
        start = 1'b1;
        start_layer = 32'd5;
        tick();
        start_layer = 32'd7;
        #1;
        check_val("t3_busy", 64'(busy), 64'd1);
        tick();
        start = 1'b0;
        #1;
        check_val("t3_rd_layer", 64'(read_layer_index), 64'd5);
        tick();
        check_val("t3_row1_data", 64'(row_data), 64'(mem[5][1]));
        tick();
        check_val("t3_row2_data", 64'(row_data), 64'(mem[5][2]));
        tick();
        check_val("t3_done", 64'(done), 64'd1);
        tick();
        check_val("t3_idle", 64'(busy), 64'd0);
        run_full(7);

        // Reset mid-stream
        start = 1'b1;
        start_layer = 32'd5;
        tick();
        start = 1'b0;
        tick();
        tick();
        check_val("t4_pre_index", 64'(row_index), 64'd1);
        reset = 1'b1;
        #1;
        check_val("t4_valid", 64'(row_valid), 64'd0);
        check_val("t4_busy", 64'(busy), 64'd0);
        check_val("t4_is_read", 64'(is_read), 64'd0);
        check_val("t4_data", 64'(row_data), 64'd0);
        check_val("t4_index", 64'(row_index), 64'd0);
        check_val("t4_rd_layer", 64'(read_layer_index), 64'd0);
        check_val("t4_done", 64'(done), 64'd0);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val("t4_no_done", 64'(done), 64'd0);
            check_val("t4_no_busy", 64'(busy), 64'd0);
        end
        run_full(0);

        // Same-cycle write-through on row 2
        start = 1'b1;
        start_layer = 32'd5;
        tick();
        start = 1'b0;
        tick();
        tick();
        wr_en = 1'b1;
        wr_layer = 32'd5;
        wr_row = 32'd2;
        wr_data = {16'hFF00, 16'hFF00, 16'hFF00};
        #1;
        check_val("t5_is_read", 64'(is_read), 64'd1);
        check_val("t5_rd_row", 64'(read_row_index), 64'd2);
        tick();
        mem[5][2] = wr_data;
        wr_en = 1'b0;
        check_val("t5_row2_data", 64'(row_data), 64'hFF00FF00FF00);
        check_val("t5_row2_last", 64'(row_last), 64'd1);
        tick();
        check_val("t5_done", 64'(done), 64'd1);
        tick();

        // Out-of-range start layer
        start = 1'b1;
        start_layer = 32'd36;
        tick();
        start = 1'b0;
        #1;
`ifdef MATRIX_READER_LAYER_CHECK_EN
        check_val("t6_err", 64'(err), 64'd1);
        check_val("t6_busy", 64'(busy), 64'd0);
        check_val("t6_is_read", 64'(is_read), 64'd0);
        tick();
        check_val("t6_err_clear", 64'(err), 64'd0);
        check_val("t6_busy2", 64'(busy), 64'd0);
        check_val("t6_is_read2", 64'(is_read), 64'd0);
`else
        check_val("t6_err", 64'(err), 64'd0);
        check_val("t6_busy", 64'(busy), 64'd1);
        seen_done = 0;
        seen_err = 0;
        for (int k = 0; k < 20 && seen_done == 0; k++) begin
            tick();
            if (err) seen_err = 1;
            if (done) seen_done = 1;
        end
        check_val("t6_done_seen", 64'(seen_done), 64'd1);
        check_val("t6_err_never", 64'(seen_err), 64'd0);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/matrix_row_reader.md
Name: matrix_row_reader

Overview:
- Read-side sequencer for the per-layer matrix store.
- On a start request for one layer, issues row reads 0..size-1 through the store's read port.
- Registers each returned row and delivers it downstream over a valid/ready stream.
- Pulses done after the last row is accepted; feeds the datapath consumers of stored weight matrices.

Parameters:
size, 3, rows per matrix and elements per row
data_size, 16, bits per element (signed Q8.8)
max_layer, 36, number of layers held in the store

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous active-high reset
start  input  1  request to stream one layer; sampled only in IDLE
start_layer  input  32  layer to stream; latched on accepted start
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse after last row handshake
err  output  1  one-cycle pulse on rejected start (see Optional Feature)
read_layer_index  output  32  to store read port
read_row_index  output  32  to store read port
is_read  output  1  to store read port
read_data  input  data_size*size  from store, combinational in same cycle as is_read
row_data  output  data_size*size  current row, element 0 in MSBs
row_index  output  32  row number of row_data
row_last  output  1  row_data is row size-1
row_valid  output  1  row_data is valid
row_ready  input  1  consumer accepts row_data when row_valid&row_ready

Behaviour:
- Reset (async, any time including mid-stream): state IDLE, row_ptr 0, latched layer 0, all outputs 0. Partial stream is abandoned; no done pulse.
- States: IDLE, STREAM, FINISH.
- IDLE: busy=0, is_read=0. start=1 latches start_layer, sets row_ptr=0, goes to STREAM with busy=1 next cycle. start while busy is ignored.
- STREAM, read issue (combinational):
  - is_read = (row_ptr<size) && (!row_valid || row_ready).
  - read_layer_index = latched layer; read_row_index = row_ptr.
  - Outside STREAM, read indices are 0.
- STREAM, edge with is_read:
  - row_data<=read_data, row_valid<=1, row_index<=row_ptr, row_last<=(row_ptr==size-1), row_ptr<=row_ptr+1.
- Edge with handshake and no new read: row_valid<=0.
- Backpressure: row_valid && !row_ready holds row_data/row_index/row_last stable and suppresses is_read. No row is dropped or duplicated.
- Throughput: one row per cycle with row_ready held high.
  - Start accepted at edge 0; row r valid after edge r+1; done after edge size+1.
- Last-row handshake (row_valid&row_ready&row_last): row_valid<=0, go to FINISH.
- FINISH: done=1 for exactly one cycle, busy stays 1, then IDLE with busy=0. Next start is accepted in IDLE only.
- A store write to the same layer/row in the same cycle as the read is returned by the store's write-through. The reader captures that value; no extra hazard logic.
- size=1 is legal: a single row with row_last=1.

Optional Feature:
- Macro: MATRIX_READER_LAYER_CHECK_EN.
- Defined: start with start_layer>=max_layer is rejected. err pulses one cycle, state stays IDLE, busy stays 0, no reads issued.
- Undefined: the layer is not checked, all starts are accepted, and err is tied 0.

Decomposition:
- Shared package matrix_pkg: MATRIX_SIZE/DATA_SIZE/MAX_LAYER defaults, typedef row_t (logic [DATA_SIZE*MATRIX_SIZE-1:0]), element typedef elem_t (signed [DATA_SIZE-1:0]), reader state enum.
- Single module; no sub-module warranted. The output register is a few lines of the same always block.

Test Plan:
- Preload layer 5 rows {1.0,2.0,3.0},{4.0,5.0,6.0},{7.0,8.0,9.0} (0x0100..0x0900), row_ready=1, start layer 5 -> rows 0,1,2 on consecutive cycles, row_last only on row 2, done pulse the following cycle, then busy=0.
- Same layer, row_ready low 3 cycles while row 1 is presented -> row 1 held stable, is_read=0 during stall, rows arrive in order 0,1,2 exactly once.
- Assert start again while busy=1 with layer 7 -> ignored; stream continues on layer 5; next start after done streams layer 7.
- Assert reset while row 1 is valid -> all outputs 0 immediately; no done; fresh start on layer 0 streams correctly.
- Write 0xFF00 to layer 5 row 2 in the same cycle the reader issues row 2 -> delivered row 2 equals the written data.
- With MATRIX_READER_LAYER_CHECK_EN, start layer 36 -> err pulses one cycle, busy stays 0, is_read never asserts. Without the macro, err stays 0.
